// File: rtl/alu_seq_pkg.sv
// Shared constants and state type for the RV32I ALU instruction sequencer.
package alu_seq_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_WB    = 2'd3
  } state_t;

endpackage

// File: rtl/alu_insn_sequencer_if.sv
// Instruction handshake between the fetch/issue side and the ALU sequencer.
interface alu_insn_sequencer_if #(parameter int XLEN = 32);
  logic                      insn_valid;
  logic                      insn_ready;
  logic [31:0]               INSN;
  logic [$clog2(XLEN)-1:0]   rs2_shamt;

  modport master (output insn_valid, INSN, rs2_shamt, input insn_ready);
  modport slave  (input insn_valid, INSN, rs2_shamt, output insn_ready);
endinterface

// File: rtl/alu_seq_decode.sv
// Combinational decode of a latched OP / OP-IMM word into ALU control and shift amount.
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]             insn,
  input  logic [$clog2(XLEN)-1:0] rs2_shamt,
  output logic                    sub_sra,
  output logic                    alu_src_imm,
  output logic                    illegal,
  output logic                    is_shift,
  output logic [$clog2(XLEN)-1:0] shamt
);
  localparam int SHW = $clog2(XLEN);

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       op_imm, op_r, f7_ok;
  logic       unused_bits;

  assign opc    = insn[6:0];
  assign f3     = insn[14:12];
  assign f7     = insn[31:25];
  assign op_imm = (opc == OPC_OP_IMM);
  assign op_r   = (opc == OPC_OP);
  assign f7_ok  = (f7 == FUNCT7_BASE) || (f7 == FUNCT7_ALT);
  assign unused_bits = ^{insn[19:15], insn[11:7]};

  always_comb begin
    illegal = 1'b0;
    if (!op_imm && !op_r)
      illegal = 1'b1;
    else if (op_imm) begin
      if (f3 == F3_SLL && f7 != FUNCT7_BASE) illegal = 1'b1;
      if (f3 == F3_SR  && !f7_ok)            illegal = 1'b1;
    end else begin
      if (!f7_ok)                                             illegal = 1'b1;
      if (f7 == FUNCT7_ALT && f3 != F3_ADD && f3 != F3_SR)    illegal = 1'b1;
    end
  end

  assign alu_src_imm = op_imm;
  assign is_shift    = (f3 == F3_SLL) || (f3 == F3_SR);
  // Compares need the subtractor; sra/srai and sub reuse the same select via bit 30.
  assign sub_sra     = (f3[2:1] == 2'b01)
                     | ((f3 == F3_SR) & insn[30])
                     | (op_r & (f3 == F3_ADD) & insn[30]);
  assign shamt       = !is_shift ? '0 : (op_imm ? insn[20 +: SHW] : rs2_shamt);

endmodule

// File: rtl/alu_insn_sequencer.sv
// Multi-cycle control sequencer for RV32I OP / OP-IMM instructions.
// ALU_SEQ_ITERATIVE_SHIFT_EN enables the SHIFT state and stepped shift schedule.
module alu_insn_sequencer
  import alu_seq_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHAMT_STEP = 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  alu_insn_sequencer_if.slave     bus,
  output logic [2:0]              alu_func3,
  output logic                    alu_src_imm,
  output logic                    sub_sra,
  output logic                    addr_sel,
  output logic                    pc_next_sel,
  output logic                    pc_alu_sel,
  output logic                    mem_clk,
  output logic                    shift_step,
  output logic [$clog2(XLEN)-1:0] shift_by,
  output logic                    rd_we,
  output logic                    illegal,
  output logic                    busy
);
  localparam int SHW = $clog2(XLEN);

  state_t          state;
  logic [31:0]     insn_q;
  logic [SHW-1:0]  rs2_q;

  logic            dec_sub, dec_imm, dec_ill, dec_shift;
  logic [SHW-1:0]  dec_shamt;

  alu_seq_decode #(.XLEN(XLEN)) u_dec (
    .insn        (insn_q),
    .rs2_shamt   (rs2_q),
    .sub_sra     (dec_sub),
    .alu_src_imm (dec_imm),
    .illegal     (dec_ill),
    .is_shift    (dec_shift),
    .shamt       (dec_shamt)
  );

`ifdef ALU_SEQ_ITERATIVE_SHIFT_EN
  localparam logic [SHW-1:0] STEP = SHW'(SHAMT_STEP);
  logic [SHW-1:0] rem_q, step_by;

  assign step_by    = (state == ST_SHIFT) ? ((rem_q < STEP) ? rem_q : STEP) : '0;
  assign shift_by   = step_by;
  assign shift_step = (state == ST_SHIFT);
`else
  logic unused_dec;
  assign unused_dec = ^{dec_shift, dec_shamt};
  assign shift_by   = '0;
  assign shift_step = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      insn_q <= '0;
      rs2_q  <= '0;
`ifdef ALU_SEQ_ITERATIVE_SHIFT_EN
      rem_q  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (bus.insn_valid) begin
          insn_q <= bus.INSN;
          rs2_q  <= bus.rs2_shamt;
          state  <= ST_EXEC;
        end
        ST_EXEC: begin
          if (dec_ill)
            state <= ST_IDLE;
`ifdef ALU_SEQ_ITERATIVE_SHIFT_EN
          else if (dec_shift && dec_shamt != '0) begin
            rem_q <= dec_shamt;
            state <= ST_SHIFT;
          end
`endif
          else
            state <= ST_WB;
        end
`ifdef ALU_SEQ_ITERATIVE_SHIFT_EN
        ST_SHIFT: begin
          rem_q <= rem_q - step_by;
          if (rem_q == step_by) state <= ST_WB;
        end
`endif
        ST_WB:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decoded controls are held at zero whenever no instruction is in flight.
  assign busy           = (state != ST_IDLE);
  assign bus.insn_ready = (state == ST_IDLE);
  assign alu_func3      = busy ? insn_q[14:12] : 3'b000;
  assign alu_src_imm    = busy & dec_imm;
  assign sub_sra        = busy & dec_sub;
  assign illegal        = (state == ST_EXEC) & dec_ill;
  assign rd_we          = (state == ST_WB);
  assign addr_sel       = 1'b0;
  assign pc_next_sel    = 1'b0;
  assign pc_alu_sel     = 1'b0;
  assign mem_clk        = 1'b0;

endmodule

// File: doc/alu_insn_sequencer.md
Name: alu_insn_sequencer

Overview:
- Parametrised, multi-cycle control sequencer for RV32I ALU instructions: OP-IMM (0010011) and OP (0110011).
- Accepts an instruction over a valid/ready handshake, registers it, and drives the existing control outputs to the datapath: addr_sel, pc_next_sel, pc_alu_sel, sub_sra and mem_clk.
- Adds a one-cycle register-write strobe and an iterative shifter schedule.
- Sits in Control_Unit beside the per-format decoders and replaces the purely combinational ALU-decode path.

Parameters:
- XLEN, 32: datapath width; shift amount width SHW = $clog2(XLEN).
- SHAMT_STEP, 1: maximum bits shifted per SHIFT cycle. Legal range 1..XLEN-1.

Ports:
- CLK  in  1  processor clock.
- RST_N  in  1  asynchronous, active-low reset.
- insn_valid  in  1  INSN is valid.
- insn_ready  out  1  sequencer can accept an instruction.
- INSN  in  32  instruction word.
- rs2_shamt  in  SHW  rs2[SHW-1:0]; shift amount for R-type shifts, sampled at acceptance.
- alu_func3  out  3  registered func3.
- alu_src_imm  out  1  1 = immediate operand (OP-IMM).
- sub_sra  out  1  ALU subtract / arithmetic-shift select.
- addr_sel, pc_next_sel, pc_alu_sel  out  1 each  always 0 for this block.
- mem_clk  out  1  always 0.
- shift_step  out  1  datapath applies one shift increment this cycle.
- shift_by  out  SHW  size of this cycle's shift increment.
- rd_we  out  1  one-cycle write strobe for rd.
- illegal  out  1  one-cycle pulse: instruction rejected.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, RST_N=0):
  - State forced to IDLE immediately, including mid-instruction; the in-flight instruction is abandoned with no rd_we.
  - All outputs are 0 except insn_ready=1.
- Handshake:
  - insn_ready = (state==IDLE).
  - Accept on a rising CLK edge with insn_valid & insn_ready; latch INSN and rs2_shamt.
  - insn_valid while busy is ignored; the source holds it until accepted.
- States: IDLE, EXEC, SHIFT, WB.
  - IDLE -accept-> EXEC.
  - EXEC:
    - illegal -> IDLE with illegal=1 for this cycle.
    - shift with non-zero amount, macro defined -> SHIFT.
    - otherwise -> WB.
  - SHIFT: remaining -= shift_by each cycle; when remaining reaches 0 -> WB.
  - WB: rd_we=1 -> IDLE.
- Latency:
  - Non-shift, or shift amount 0: rd_we in the 2nd cycle after acceptance.
  - Shift: rd_we in cycle 2 + ceil(shamt/SHAMT_STEP).
- Decoded outputs (alu_func3, alu_src_imm, sub_sra) are registered and valid from EXEC through WB; they are 0 in IDLE.
- Shift amount source:
  - OP-IMM uses INSN[24:20].
  - OP uses the latched rs2_shamt.
- shift_by = min(remaining, SHAMT_STEP). shift_step is high in every SHIFT cycle; shift_by is 0 outside SHIFT.
- sub_sra = 1 when any of:
  - func3 = 01x (slt/slti/sltu/sltiu);
  - func3 = 101 and INSN[30] (sra/srai);
  - OP with func3 = 000 and INSN[30] (sub).
- Illegal when any of:
  - opcode is neither 0010011 nor 0110011;
  - OP-IMM func3 = 001 with INSN[31:25] != 0;
  - OP-IMM func3 = 101 with INSN[31:25] not in {0x00, 0x20};
  - OP with funct7 not in {0x00, 0x20};
  - OP with funct7 = 0x20 and func3 not in {000, 101}.
  - Illegal instructions produce no rd_we and no shift_step.

Optional Feature:
- ALU_SEQ_ITERATIVE_SHIFT_EN defined: the SHIFT state exists and shifts proceed in SHAMT_STEP increments as above.
- Undefined:
  - SHIFT state is removed; shift_step and shift_by are tied to 0.
  - All legal instructions take EXEC -> WB (fixed 2-cycle latency); the datapath uses a full barrel shifter.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants OPC_OP_IMM and OPC_OP;
  - func3 constants F3_ADD through F3_AND;
  - FUNCT7_BASE = 7'h00 and FUNCT7_ALT = 7'h20;
  - the state enum type.
- One natural sub-module: alu_seq_decode, combinational. It maps the registered INSN to sub_sra, alu_src_imm, illegal, is_shift and the shift amount. The FSM, counter and handshake stay in the top module.

Test Plan:
- Bench defaults: XLEN=32, SHAMT_STEP=1, macro defined.
- addi 0x00500093 accepted -> alu_src_imm=1, sub_sra=0, func3=000; rd_we pulses in cycle 2; insn_ready returns to 1 in cycle 3.
- srai 0x40515093 -> sub_sra=1; five shift_step cycles with shift_by=1; rd_we in cycle 7. Repeat with SHAMT_STEP=4 -> shift_by sequence 4,1; rd_we in cycle 4.
- sub 0x402081B3 -> alu_src_imm=0, sub_sra=1, rd_we in cycle 2. sltiu 0x00113093 -> sub_sra=1, rd_we in cycle 2.
- slli with funct7 0x20 (0x40511093) -> illegal pulse in cycle 1; no rd_we; insn_ready=1 in cycle 2.
- sll (0x002091B3) with rs2_shamt=0 -> no shift_step; rd_we in cycle 2.
- RST_N low during the 3rd SHIFT cycle of srai 0x40515093 -> all outputs 0 and insn_ready=1 asynchronously; no rd_we. After release, addi is accepted and completes normally.
- insn_valid held high while busy -> exactly one acceptance per instruction.
